// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the register-file write-back arbiter: two push handshakes,
// the registered write port, and the hazard-query lookup.
interface regfile_wb_arbiter_if;
  logic        aluValid;
  logic        aluReady;
  logic [4:0]  aluAddr;
  logic [31:0] aluData;
  logic        memValid;
  logic        memReady;
  logic [4:0]  memAddr;
  logic [31:0] memData;
  logic        RegWrite;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [4:0]  qAddrA;
  logic [4:0]  qAddrB;
  logic        pendA;
  logic        pendB;
  logic        busy;

  modport master (
    output aluValid, aluAddr, aluData, memValid, memAddr, memData, qAddrA, qAddrB,
    input  aluReady, memReady, RegWrite, wrAddr, wrData, pendA, pendB, busy
  );

  modport slave (
    input  aluValid, aluAddr, aluData, memValid, memAddr, memData, qAddrA, qAddrB,
    output aluReady, memReady, RegWrite, wrAddr, wrData, pendA, pendB, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter: ALU and load-unit FIFOs drain onto the single
// registered register-file write port, with pending-write hazard lookup.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {REQ_ALU = 1'b0, REQ_MEM = 1'b1} req_e;

  // Index 0 is the ALU queue, index 1 the load queue.
  logic [4:0]    r_addr   [2][DEPTH];
  logic [31:0]   r_data   [2][DEPTH];
  logic [PW-1:0] r_wr_ptr [2];
  logic [PW-1:0] r_rd_ptr [2];
  logic [CW-1:0] r_cnt    [2];
  req_e          r_last_gnt;
  logic          r_reg_write;
  logic [4:0]    r_wr_addr;
  logic [31:0]   r_wr_data;

  logic [1:0]       w_valid, w_full, w_empty, w_push, w_pop;
  logic [4:0]       w_in_addr [2];
  logic [31:0]      w_in_data [2];
  logic             w_gnt_any;
  req_e             w_sel;
  logic [4:0]       w_head_addr;
  logic [31:0]      w_head_data;
  logic [PW-1:0]    w_off [2][DEPTH];
  logic [DEPTH-1:0] w_slot_vld [2];
  logic             w_pend_a, w_pend_b;

  assign w_valid      = {bus.memValid, bus.aluValid};
  assign w_in_addr[0] = bus.aluAddr;
  assign w_in_addr[1] = bus.memAddr;
  assign w_in_data[0] = bus.aluData;
  assign w_in_data[1] = bus.memData;

  assign w_full[0]  = (r_cnt[0] == CW'(DEPTH));
  assign w_full[1]  = (r_cnt[1] == CW'(DEPTH));
  assign w_empty[0] = (r_cnt[0] == '0);
  assign w_empty[1] = (r_cnt[1] == '0);
  assign w_push     = w_valid & ~w_full & {2{~reset}};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_sel = REQ_ALU;
    if (!w_empty[0] && !w_empty[1]) begin
      w_sel = (r_last_gnt == REQ_ALU) ? REQ_MEM : REQ_ALU;
    end else if (w_empty[0]) begin
      w_sel = REQ_MEM;
    end
  end

  assign w_gnt_any   = ~(w_empty[0] & w_empty[1]);
  assign w_pop       = {w_gnt_any && (w_sel == REQ_MEM), w_gnt_any && (w_sel == REQ_ALU)};
  assign w_head_addr = (w_sel == REQ_MEM) ? r_addr[1][r_rd_ptr[1]] : r_addr[0][r_rd_ptr[0]];
  assign w_head_data = (w_sel == REQ_MEM) ? r_data[1][r_rd_ptr[1]] : r_data[0][r_rd_ptr[0]];

  // NOTE: sequential state uses non-blocking assignments only, so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end else begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PW'(1);
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
        r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the count alone decides which slots are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) begin
        r_addr[i][r_wr_ptr[i]] <= w_in_addr[i];
        r_data[i][r_wr_ptr[i]] <= w_in_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt  <= REQ_MEM;
      r_reg_write <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else if (w_gnt_any) begin
      r_last_gnt  <= w_sel;
      r_reg_write <= 1'b1;
      r_wr_addr   <= w_head_addr;
      r_wr_data   <= w_head_data;
    end else begin
      r_reg_write <= 1'b0;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_slot_vld[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        w_off[i][j]      = PW'(j) - r_rd_ptr[i];
        w_slot_vld[i][j] = ({1'b0, w_off[i][j]} < r_cnt[i]);
      end
    end
  end

  always_comb begin
    w_pend_a = r_reg_write && (r_wr_addr == bus.qAddrA);
    w_pend_b = r_reg_write && (r_wr_addr == bus.qAddrB);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (w_slot_vld[i][j] && (r_addr[i][j] == bus.qAddrA)) w_pend_a = 1'b1;
        if (w_slot_vld[i][j] && (r_addr[i][j] == bus.qAddrB)) w_pend_b = 1'b1;
      end
    end
  end

  assign bus.aluReady = !w_full[0] && !reset;
  assign bus.memReady = !w_full[1] && !reset;
  assign bus.RegWrite = r_reg_write;
  assign bus.wrAddr   = r_wr_addr;
  assign bus.wrData   = r_wr_data;
  assign bus.pendA    = w_pend_a && !reset;
  assign bus.pendB    = w_pend_b && !reset;
  assign bus.busy     = ((r_cnt[0] != '0) || (r_cnt[1] != '0) || r_reg_write) && !reset;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter (DEPTH=2) with hand-computed expectations.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_miss = 0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.aluValid = v;
    bus.aluAddr  = a;
    bus.aluData  = d;
  endtask

  task automatic drive_mem(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.memValid = v;
    bus.memAddr  = a;
    bus.memData  = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_port(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_rw"},   32'(bus.RegWrite), 32'd1);
    check({tag, "_addr"}, 32'(bus.wrAddr),   32'(a));
    check({tag, "_data"}, bus.wrData,        d);
  endtask

  // Backpressure scenario: inputs presented before edges 1..6 and the resulting port order.
  logic [4:0] bp_alu_a  [6] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd13, 5'd14};
  logic [4:0] bp_mem_a  [6] = '{5'd20, 5'd21, 5'd22, 5'd22, 5'd23, 5'd23};
  logic       bp_alu_rdy[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       bp_mem_rdy[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [4:0] bp_port_a [8] = '{5'd10, 5'd20, 5'd11, 5'd21, 5'd12, 5'd22, 5'd13, 5'd23};

  initial begin
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_mem(1'b0, 5'd0, 32'd0);
    bus.qAddrA = 5'd0;
    bus.qAddrB = 5'd0;

    // Reset state.
    tick();
    tick();
    check("rst_aluReady", 32'(bus.aluReady), 32'd0);
    check("rst_memReady", 32'(bus.memReady), 32'd0);
    check("rst_RegWrite", 32'(bus.RegWrite), 32'd0);
    check("rst_wrAddr",   32'(bus.wrAddr),   32'd0);
    check("rst_wrData",   bus.wrData,        32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_pendA",    32'(bus.pendA),    32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_aluReady", 32'(bus.aluReady), 32'd1);

    // Single write, latency and hazard window.
    bus.qAddrA = 5'd5;
    bus.qAddrB = 5'd0;
    drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check("single_pendA_e0", 32'(bus.pendA), 32'd0);
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    check("single_pendA_e1", 32'(bus.pendA),    32'd1);
    check("single_rw_e1",    32'(bus.RegWrite), 32'd0);
    check("single_busy_e1",  32'(bus.busy),     32'd1);
    tick();
    check_port("single_e2", 5'd5, 32'hDEADBEEF);
    check("single_pendA_e2", 32'(bus.pendA), 32'd1);
    check("single_pendB_e2", 32'(bus.pendB), 32'd0);
    tick();
    check("single_rw_e3",    32'(bus.RegWrite), 32'd0);
    check("single_hold_e3",  32'(bus.wrAddr),   32'd5);
    check("single_pendA_e3", 32'(bus.pendA),    32'd0);
    check("single_busy_e3",  32'(bus.busy),     32'd0);

    // Tie round-robin from a fresh reset.
    do_reset();
    drive_alu(1'b1, 5'd1, 32'd11);
    drive_mem(1'b1, 5'd2, 32'd22);
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_mem(1'b0, 5'd0, 32'd0);
    check("tie_rw_e1", 32'(bus.RegWrite), 32'd0);
    tick();
    check_port("tie_first", 5'd1, 32'd11);
    tick();
    check_port("tie_second", 5'd2, 32'd22);
    drive_alu(1'b1, 5'd3, 32'd33);
    drive_mem(1'b1, 5'd4, 32'd44);
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_mem(1'b0, 5'd0, 32'd0);
    check("tie2_rw_e1", 32'(bus.RegWrite), 32'd0);
    tick();
    check_port("tie2_first", 5'd3, 32'd33);
    tick();
    check_port("tie2_second", 5'd4, 32'd44);
    tick();
    check("tie_idle_busy", 32'(bus.busy), 32'd0);

    // Backpressure with MEM held valid for 6 cycles under ALU contention.
    for (int c = 0; c < 6; c++) begin
      drive_alu(1'b1, bp_alu_a[c], 32'(bp_alu_a[c]) + 32'd100);
      drive_mem(1'b1, bp_mem_a[c], 32'(bp_mem_a[c]) + 32'd100);
      #1;
      check($sformatf("bp_aluReady_%0d", c), 32'(bus.aluReady), 32'(bp_alu_rdy[c]));
      check($sformatf("bp_memReady_%0d", c), 32'(bus.memReady), 32'(bp_mem_rdy[c]));
      tick();
      if (c >= 1) check_port($sformatf("bp_port_%0d", c - 1), bp_port_a[c - 1],
                             32'(bp_port_a[c - 1]) + 32'd100);
    end
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_mem(1'b0, 5'd0, 32'd0);
    for (int k = 5; k < 8; k++) begin
      tick();
      check_port($sformatf("bp_port_%0d", k), bp_port_a[k], 32'(bp_port_a[k]) + 32'd100);
    end
    tick();
    check("bp_drain_rw",   32'(bus.RegWrite), 32'd0);
    check("bp_drain_busy", 32'(bus.busy),     32'd0);

    // Same-requester ordering to one register.
    bus.qAddrA = 5'd7;
    bus.qAddrB = 5'd8;
    drive_alu(1'b1, 5'd7, 32'd1);
    tick();
    drive_alu(1'b1, 5'd7, 32'd2);
    check("ord_pendA_e1", 32'(bus.pendA), 32'd1);
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    check_port("ord_first", 5'd7, 32'd1);
    check("ord_pendA_e2", 32'(bus.pendA), 32'd1);
    check("ord_pendB_e2", 32'(bus.pendB), 32'd0);
    tick();
    check_port("ord_second", 5'd7, 32'd2);
    check("ord_pendA_e3", 32'(bus.pendA), 32'd1);
    tick();
    check("ord_rw_e4",    32'(bus.RegWrite), 32'd0);
    check("ord_final_r7", bus.wrData,        32'd2);
    check("ord_pendA_e4", 32'(bus.pendA),    32'd0);

    // Reset in the middle of traffic.
    bus.qAddrA = 5'd13;
    bus.qAddrB = 5'd23;
    drive_alu(1'b1, 5'd12, 32'd120);
    drive_mem(1'b1, 5'd22, 32'd220);
    tick();
    drive_alu(1'b1, 5'd13, 32'd130);
    drive_mem(1'b1, 5'd23, 32'd230);
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_mem(1'b0, 5'd0, 32'd0);
    check("mid_pendA_pre", 32'(bus.pendA), 32'd1);
    check("mid_busy_pre",  32'(bus.busy),  32'd1);
    reset = 1'b1;
    #1;
    check("mid_aluReady_inrst", 32'(bus.aluReady), 32'd0);
    check("mid_memReady_inrst", 32'(bus.memReady), 32'd0);
    check("mid_pendA_inrst",    32'(bus.pendA),    32'd0);
    check("mid_busy_inrst",     32'(bus.busy),     32'd0);
    tick();
    reset = 1'b0;
    check("mid_rw_post",    32'(bus.RegWrite), 32'd0);
    check("mid_wrAddr_post", 32'(bus.wrAddr),  32'd0);
    check("mid_busy_post",  32'(bus.busy),     32'd0);
    check("mid_pendA_post", 32'(bus.pendA),    32'd0);
    check("mid_pendB_post", 32'(bus.pendB),    32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mid_no_write_%0d", k), 32'(bus.RegWrite), 32'd0);
    end
    bus.qAddrA = 5'd9;
    drive_alu(1'b1, 5'd9, 32'd99);
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    check("resume_pendA", 32'(bus.pendA), 32'd1);
    tick();
    check_port("resume", 5'd9, 32'd99);
    tick();
    check("resume_busy", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
